// File: rtl/ctrl_pkg.sv
// Shared types and constants for the Salamander-4 control unit.
// Instruction field layout and decoder opcodes live here too.
package ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      HALT
   } ctrl_state_t;

   localparam int INSTR_W    = 6;
   localparam int ACC_CE_BIT = 5;
   localparam int OP_HI      = 4;
   localparam int OP_LO      = 2;
   localparam int ADDR_HI    = 1;
   localparam int ADDR_LO    = 0;

   localparam logic [2:0] OP_LD  = 3'd0;
   localparam logic [2:0] OP_ST  = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_XOR = 3'd6;
   localparam logic [2:0] OP_NOP = 3'd7;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/ctrl_unit_if.sv
// Program-memory fetch handshake between the control unit and imem.
// The control unit is the master; memory answers with ack and data.
interface ctrl_unit_if #(
   parameter int PC_W = 4
) ();

   logic            IMEM_REQ;
   logic [PC_W-1:0] IMEM_ADDR;
   logic            IMEM_ACK;
   logic [5:0]      IMEM_DATA;

   modport master (
      output IMEM_REQ,
      output IMEM_ADDR,
      input  IMEM_ACK,
      input  IMEM_DATA
   );

   modport slave (
      input  IMEM_REQ,
      input  IMEM_ADDR,
      output IMEM_ACK,
      output IMEM_DATA
   );

endinterface

// File: rtl/ctrl_unit_pc_reg.sv
// Program counter with increment enable and end-of-program compare.
// An end address outside the PC range simply never matches.
module pc_reg #(
   parameter int PC_W     = 4,
   parameter int PROG_END = 15
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            INC,
   output logic [PC_W-1:0] PC,
   output logic            AT_END
);

   localparam logic [31:0] END_C = PROG_END;

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (INC) pc_d = pc_q + PC_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) pc_q <= '0;
      else        pc_q <= pc_d;
   end

   assign PC     = pc_q;
   assign AT_END = (32'(pc_q) == END_C);

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the Salamander-4 core.
// Owns the PC, run/halt control and the retired-instruction counter.
module ctrl_unit
   import ctrl_pkg::*;
#(
   parameter int PC_W     = 4,
   parameter int PROG_END = 15
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               RUN,
   input  logic               HALT_REQ,
   ctrl_unit_if.master        imem,
   output logic [INSTR_W-1:0] INSTR,
   output logic               ID_CE,
   output logic               BUSY,
   output logic               HALTED,
   output logic [7:0]         INSTR_CNT
);

   ctrl_state_t        state_q, state_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               hp_q, hp_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               pc_inc;
   logic               at_end;
   logic [PC_W-1:0]    pc;

   pc_reg #(
      .PC_W     (PC_W),
      .PROG_END (PROG_END)
   ) u_pc (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .INC    (pc_inc),
      .PC     (pc),
      .AT_END (at_end)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= IDLE;
         instr_q <= '0;
         hp_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         hp_q    <= hp_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      hp_d    = hp_q;
      cnt_d   = cnt_q;
      pc_inc  = 1'b0;
      if (HALT_REQ && state_q != HALT) hp_d = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (RUN) state_d = FETCH;
         end
         FETCH: begin
            if (imem.IMEM_ACK) begin
               instr_d = imem.IMEM_DATA;
               state_d = DECODE;
            end
         end
         DECODE: state_d = EXEC;
         EXEC: begin
            pc_inc = 1'b1;
            cnt_d  = sat_inc(cnt_q);
            // a request arriving during EXEC still stops at this edge
            if (hp_q || HALT_REQ || at_end) state_d = HALT;
            else                            state_d = FETCH;
         end
         HALT: begin
            if (RUN) begin
               hp_d    = 1'b0;
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign imem.IMEM_REQ  = (state_q == FETCH);
   assign imem.IMEM_ADDR = pc;
   assign ID_CE          = (state_q == EXEC);
   assign BUSY           = (state_q == FETCH) ||
                           (state_q == DECODE) ||
                           (state_q == EXEC);
   assign HALTED         = (state_q == HALT);
   assign INSTR          = instr_q;
   assign INSTR_CNT      = cnt_q;

endmodule

// File: tb/tb_ctrl_unit.sv
// Scoreboard bench for ctrl_unit: directed runs, waits, halts, reset.
// A second instance with an unreachable end address checks saturation.
`timescale 1ns/1ps
module tb_ctrl_unit;

   typedef struct {
      logic [5:0] instr;
      logic [3:0] addr;
      int         gap;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RST_N, RUN, HALT_REQ;
   logic [5:0] INSTR;
   logic       ID_CE, BUSY, HALTED;
   logic [7:0] CNT;

   logic       RST2_N, RUN2, HALT_REQ2;
   logic [5:0] INSTR2;
   logic       ID_CE2, BUSY2, HALTED2;
   logic [7:0] CNT2;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int last_ce = 0;
   logic [5:0] last_instr = '0;
   exp_t sb[$];

   logic [5:0] mem [16];
   int   delay = 0;
   bit   force_ack = 1'b0;
   int   wcnt = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   ctrl_unit_if #(.PC_W(4)) bus ();
   ctrl_unit_if #(.PC_W(4)) bus2 ();

   ctrl_unit #(.PC_W(4), .PROG_END(15)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .RUN       (RUN),
      .HALT_REQ  (HALT_REQ),
      .imem      (bus),
      .INSTR     (INSTR),
      .ID_CE     (ID_CE),
      .BUSY      (BUSY),
      .HALTED    (HALTED),
      .INSTR_CNT (CNT)
   );

   ctrl_unit #(.PC_W(4), .PROG_END(20)) dut2 (
      .CLK       (CLK),
      .RST_N     (RST2_N),
      .RUN       (RUN2),
      .HALT_REQ  (HALT_REQ2),
      .imem      (bus2),
      .INSTR     (INSTR2),
      .ID_CE     (ID_CE2),
      .BUSY      (BUSY2),
      .HALTED    (HALTED2),
      .INSTR_CNT (CNT2)
   );

   assign bus2.IMEM_ACK  = 1'b1;
   assign bus2.IMEM_DATA = {2'b00, bus2.IMEM_ADDR};

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // program memory with a configurable number of wait cycles
   initial begin
      bus.IMEM_ACK  = 1'b0;
      bus.IMEM_DATA = 6'h3F;
      forever begin
         @(negedge CLK);
         if (bus.IMEM_REQ) begin
            if (wcnt >= delay) begin
               bus.IMEM_ACK  = 1'b1;
               bus.IMEM_DATA = mem[bus.IMEM_ADDR];
               wcnt = 0;
            end else begin
               bus.IMEM_ACK  = 1'b0;
               bus.IMEM_DATA = 6'h3F;
               wcnt++;
            end
         end else begin
            bus.IMEM_ACK  = force_ack;
            bus.IMEM_DATA = 6'h3F;
            wcnt = 0;
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (RST_N === 1'b1) begin
            if (bus.IMEM_REQ) chk("instr_hold", INSTR, last_instr);
            if (ID_CE) begin
               if (sb.size() == 0) begin
                  chk("unexpected_ce", 32'(sb.size()), 1);
               end else begin
                  e = sb.pop_front();
                  chk("ce_instr", INSTR, e.instr);
                  chk("ce_addr", bus.IMEM_ADDR, e.addr);
                  if (e.gap != 0) chk("ce_gap", cyc - last_ce, e.gap);
                  last_ce    = cyc;
                  last_instr = e.instr;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input logic [5:0] i, input logic [3:0] a,
                       input int g);
      exp_t e;
      e.instr = i;
      e.addr  = a;
      e.gap   = g;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      RST_N    = 1'b0;
      RUN      = 1'b0;
      HALT_REQ = 1'b0;
      tick();
      tick();
      last_instr = '0;
      RST_N = 1'b1;
   endtask

   task automatic wait_halt(input int budget, output int n);
      n = 0;
      while (!HALTED && n < budget) begin
         tick();
         n++;
      end
      if (!HALTED) chk("halt_timeout", 0, 1);
   endtask

   initial begin
      int n;
      int c0;
      RST2_N = 1'b0;
      RUN2 = 1'b0;
      HALT_REQ2 = 1'b0;

      // reset state
      do_reset();
      RST_N = 1'b0;
      tick();
      chk("rst_req", bus.IMEM_REQ, 0);
      chk("rst_ce", ID_CE, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_halted", HALTED, 0);
      chk("rst_pc", bus.IMEM_ADDR, 0);
      chk("rst_instr", INSTR, 0);
      chk("rst_cnt", CNT, 0);
      RST_N = 1'b1;

      // basic run, ack same cycle, mem[k] = k
      for (int k = 0; k < 16; k++) mem[k] = 6'(k);
      delay = 0;
      for (int k = 0; k < 16; k++) push(6'(k), 4'(k), k == 0 ? 0 : 3);
      RUN = 1'b1;
      tick();
      RUN = 1'b0;
      c0 = cyc;
      chk("start_req", bus.IMEM_REQ, 1);
      chk("start_addr", bus.IMEM_ADDR, 0);
      wait_halt(80, n);
      chk("basic_cycles", cyc - c0, 48);
      chk("basic_halted", HALTED, 1);
      chk("basic_pc", bus.IMEM_ADDR, 0);
      chk("basic_cnt", CNT, 16);

      // two wait states per fetch
      do_reset();
      for (int k = 0; k < 16; k++) mem[k] = 6'(k) ^ 6'h15;
      delay = 2;
      for (int k = 0; k < 16; k++)
         push(6'(k) ^ 6'h15, 4'(k), k == 0 ? 0 : 5);
      RUN = 1'b1;
      tick();
      RUN = 1'b0;
      wait_halt(120, n);
      chk("wait_cnt", CNT, 16);
      chk("wait_pc", bus.IMEM_ADDR, 0);

      // halt request during fetch of address 3, then resume
      do_reset();
      for (int k = 0; k < 16; k++) mem[k] = 6'h20 | 6'(k);
      delay = 0;
      for (int k = 0; k < 4; k++) push(6'h20 | 6'(k), 4'(k), 0);
      RUN = 1'b1;
      tick();
      RUN = 1'b0;
      n = 0;
      while (!(bus.IMEM_REQ && bus.IMEM_ADDR == 4'd3) && n < 40) begin
         tick();
         n++;
      end
      chk("reach_fetch3", bus.IMEM_ADDR, 3);
      HALT_REQ = 1'b1;
      tick();
      HALT_REQ = 1'b0;
      wait_halt(20, n);
      chk("mid_halted", HALTED, 1);
      chk("mid_pc", bus.IMEM_ADDR, 4);
      chk("mid_cnt", CNT, 4);
      for (int k = 4; k < 16; k++) push(6'h20 | 6'(k), 4'(k), 0);
      RUN = 1'b1;
      tick();
      RUN = 1'b0;
      chk("resume_req", bus.IMEM_REQ, 1);
      chk("resume_addr", bus.IMEM_ADDR, 4);
      wait_halt(60, n);
      chk("resume_cnt", CNT, 16);

      // run and halt together in idle
      do_reset();
      push(6'h20, 4'd0, 0);
      RUN = 1'b1;
      HALT_REQ = 1'b1;
      tick();
      RUN = 1'b0;
      HALT_REQ = 1'b0;
      wait_halt(20, n);
      chk("one_pc", bus.IMEM_ADDR, 1);
      chk("one_cnt", CNT, 1);
      chk("one_sb", 32'(sb.size()), 0);

      // reset while a fetch waits for ack
      do_reset();
      delay = 1000;
      RUN = 1'b1;
      tick();
      RUN = 1'b0;
      tick();
      tick();
      chk("mf_req_before", bus.IMEM_REQ, 1);
      RST_N = 1'b0;
      tick();
      last_instr = '0;
      chk("mf_req", bus.IMEM_REQ, 0);
      chk("mf_pc", bus.IMEM_ADDR, 0);
      chk("mf_busy", BUSY, 0);
      chk("mf_halted", HALTED, 0);
      RST_N = 1'b1;
      force_ack = 1'b1;
      tick();
      tick();
      tick();
      force_ack = 1'b0;
      delay = 0;
      chk("mf_instr", INSTR, 0);
      chk("mf_idle", BUSY, 0);

      // saturation on an instance whose end address never matches
      RST2_N = 1'b0;
      tick();
      RST2_N = 1'b1;
      RUN2 = 1'b1;
      tick();
      RUN2 = 1'b0;
      n = 0;
      c0 = 0;
      while (n < 300 && c0 < 2000) begin
         tick();
         c0++;
         if (ID_CE2) begin
            n++;
            if (n == 17) chk("sat_wrap_addr", bus2.IMEM_ADDR, 0);
            if (n == 255) chk("sat_cnt254", CNT2, 254);
            if (n == 257) chk("sat_cnt256", CNT2, 255);
            if (n == 300) HALT_REQ2 = 1'b1;
         end
      end
      chk("sat_ce_count", n, 300);
      tick();
      HALT_REQ2 = 1'b0;
      chk("sat_halted", HALTED2, 1);
      chk("sat_cnt", CNT2, 255);
      chk("sat_pc", bus2.IMEM_ADDR, 12);

      chk("sb_drained", 32'(sb.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
